risc16_fetch_unit: RTL and testbench

// - Instruction fetch stage of the 16-bit RISC core; sits upstream of the core's decode stage.
// - Owns the PC and issues word reads to a synchronous instruction memory (1-cycle read latency).
// - Buffers returned instructions in a small prefetch queue and presents them to decode with valid/ready.
// - Redirects from branch/jump resolution flush the queue and restart fetch at a new PC.

---
 rtl/risc16_fetch_unit.sv | 103 ++++++++++
 tb/tb_risc16_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_fetch_unit.sv
// Instruction fetch stage for the 16-bit RISC core: PC, 1-cycle imem reads, prefetch queue, redirect flush.
// Optional FETCH_STATS_EN adds saturating delivered/flush counters.
module risc16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_imem_addr,
  output logic        o_imem_rd,
  input  logic [15:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        i_instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] o_fetch_cnt,
  output logic [15:0] o_flush_cnt
`endif
);

  localparam int             AW = $clog2(QDEPTH);
  localparam int             CW = AW + 1;
  localparam logic [CW:0]    QD = (CW+1)'(QDEPTH);

  logic [15:0]   pc;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          rsp_vld_p1;
  logic [15:0]   rsp_pc_p1;
  logic [15:0]   q_instr [QDEPTH];
  logic [15:0]   q_pc    [QDEPTH];
  logic [CW:0]   occ;
  logic          push;
  logic          pop;

  // In-flight read holds a queue slot so a push can never land on a full queue.
  assign occ           = {1'b0, count} + {{CW{1'b0}}, rsp_vld_p1};
  assign o_imem_rd     = i_rst_n & ~i_redirect & (occ < QD);
  assign o_imem_addr   = pc;
  assign o_instr_valid = (count != '0);
  assign o_instr       = o_instr_valid ? q_instr[rptr] : 16'h0000;
  assign o_instr_pc    = o_instr_valid ? q_pc[rptr]    : 16'h0000;
  assign pop           = o_instr_valid & i_instr_ready;
  assign push          = rsp_vld_p1 & ~i_redirect;

  // Stage p0 -> p1: request issue, PC advance, queue bookkeeping
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc         <= RESET_PC;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      rsp_vld_p1 <= 1'b0;
    end else if (i_redirect) begin
      pc         <= i_redirect_pc;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      rsp_vld_p1 <= 1'b0;
    end else begin
      if (o_imem_rd) pc <= pc + 16'd1;
      rsp_vld_p1 <= o_imem_rd;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> queue: capture returned word with the PC it was fetched from
  always_ff @(posedge i_clk) begin
    if (o_imem_rd) rsp_pc_p1 <= pc;
    if (push) begin
      q_instr[wptr] <= i_imem_data;
      q_pc[wptr]    <= rsp_pc_p1;
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (pop)        o_fetch_cnt <= sat_inc(o_fetch_cnt);
      if (i_redirect) o_flush_cnt <= sat_inc(o_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_risc16_fetch_unit.sv
// Scoreboard bench for risc16_fetch_unit: expected PCs are queued by stimulus, a negedge monitor checks transfers.
module tb_risc16_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b1;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] fetch_b4;
  logic [15:0] flush_b4;
`endif

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [15:0] exp_q[$];

  risc16_fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .o_imem_addr(imem_addr),
    .o_imem_rd(imem_rd),
    .i_imem_data(imem_data),
    .i_redirect(redirect),
    .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid),
    .o_instr(instr),
    .o_instr_pc(instr_pc),
    .i_instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .o_fetch_cnt(fetch_cnt),
    .o_flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[k] = A000 + k, one-cycle latency
  always @(posedge clk) begin
    if (imem_rd === 1'b1) imem_data <= 16'hA000 + imem_addr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] start, input int n);
    logic [15:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 16'd1;
    end
  endtask

  task automatic wait_delivered(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (delivered < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, delivered, target);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    logic [15:0] ei;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc %0h instr %0h expected no transfer", instr_pc, instr);
      end else begin
        e  = exp_q.pop_front();
        ei = 16'hA000 + e;
        chk("xfer_pc", instr_pc, e);
        chk("xfer_instr", instr, ei);
      end
      delivered++;
    end
  end

  initial begin
    int nreads;
    int base;
    logic [15:0] rexp;

    // Reset state and streaming with ready held high
    rst_n = 1'b0;
    instr_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rd", imem_rd, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    push_range(16'h0000, 8);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("c1_rd", imem_rd, 1);
        chk("c1_addr", imem_addr, 16'h0000);
      end
      if (i == 2) chk("c2_valid", instr_valid, 0);
      tick();
    end
    chk("stream_no_gaps", delivered, 8);
    instr_ready = 1'b0;

    // Mid-stream reset, then fill with ready low
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rd", imem_rd, 0);
    tick();
    rst_n = 1'b1;
    nreads = 0;
    rexp = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_pc", instr_pc, 0);
        chk("midrst_restart_rd", imem_rd, 1);
      end
      if (imem_rd === 1'b1) begin
        chk("stall_read_addr", imem_addr, rexp);
        rexp = rexp + 16'd1;
        nreads++;
      end
      tick();
    end
    chk("stall_nreads", nreads, 4);
    chk("stall_head_valid", instr_valid, 1);
    chk("stall_head_instr", instr, 16'hA000);
    chk("stall_head_pc", instr_pc, 16'h0000);
    base = delivered;
    push_range(16'h0000, 10);
    instr_ready = 1'b1;
    wait_delivered(base + 10, 40, "stall_release_count");
    instr_ready = 1'b0;

    // Redirect with 3 entries queued and one read in flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("pre_redir_rd", imem_rd, 1);
    chk("pre_redir_addr", imem_addr, 16'h0003);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    chk("redir_rd_low", imem_rd, 0);
    chk("redir_head_valid", instr_valid, 1);
    tick();
    redirect = 1'b0;
    base = delivered;
    push_range(16'h0040, 6);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("redir_r1_valid", instr_valid, 0);
    chk("redir_r1_rd", imem_rd, 1);
    chk("redir_r1_addr", imem_addr, 16'h0040);
    tick();
    @(negedge clk);
    chk("redir_r2_valid", instr_valid, 0);
    tick();
    wait_delivered(base + 6, 30, "redir_count");

    // Redirect during a transfer, immediately overridden by a redirect to FFFE
    base = delivered;
`ifdef FETCH_STATS_EN
    fetch_b4 = fetch_cnt;
    flush_b4 = flush_cnt;
`endif
    exp_q.push_back(16'h0046);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    tick();
`ifdef FETCH_STATS_EN
    chk("stats_fetch_inc", fetch_cnt, 32'(fetch_b4 + 16'd1));
    chk("stats_flush_inc", flush_cnt, 32'(flush_b4 + 16'd1));
`endif
    chk("xfer_during_redir", delivered, base + 1);
    redirect_pc = 16'hFFFE;
    push_range(16'hFFFE, 4);
    @(negedge clk);
    chk("b2b_valid", instr_valid, 0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("b2b_last_wins_addr", imem_addr, 16'hFFFE);
    tick();
    wait_delivered(base + 5, 30, "wrap_count");
    instr_ready = 1'b0;
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
